// File: rtl/i2c_oled_init_seq.sv
// rtl/i2c_oled_init_seq.sv - SSD1306 I2C init command sequencer; define OLED_CLEAR_EN to append a display RAM clear
module i2c_oled_init_seq #(
  parameter int PWRUP_CYCLES = 100000,
  parameter int RETRY_MAX    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [6:0] slave_addr,
  output logic       read_write,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_last,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic       tx_nack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cmd_idx
);

  localparam int PW_W = (PWRUP_CYCLES > 0) ? $clog2(PWRUP_CYCLES + 1) : 1;
  localparam int RT_W = $clog2(RETRY_MAX + 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(RETRY_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWRUP = 3'd1;
  localparam logic [2:0] S_CTRL  = 3'd2;
  localparam logic [2:0] S_CMD   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`ifdef OLED_CLEAR_EN
  localparam logic [2:0] S_CLR   = 3'd7;
`endif

  logic [2:0]      state;
  logic [PW_W-1:0] pw_cnt;
  logic [RT_W-1:0] retry;
  logic [RT_W-1:0] retry_nxt;
  logic [1:0]      ptr;
  logic            addr_en;
  logic [25:0]     entry;
  logic [1:0]      cmd_len;
  logic [7:0]      cur_byte;
`ifdef OLED_CLEAR_EN
  logic            in_clr;
  logic            clr_hdr;
  logic [10:0]     clr_cnt;
`endif

  // Init table entry: {length, byte0, byte1, byte2}; unused bytes are zero
  function automatic logic [25:0] cmd_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_entry = {2'd1, 8'hAE, 8'h00, 8'h00};
      4'd1:    cmd_entry = {2'd2, 8'hD5, 8'h80, 8'h00};
      4'd2:    cmd_entry = {2'd2, 8'hA8, 8'h3F, 8'h00};
      4'd3:    cmd_entry = {2'd2, 8'hD3, 8'h00, 8'h00};
      4'd4:    cmd_entry = {2'd1, 8'h40, 8'h00, 8'h00};
      4'd5:    cmd_entry = {2'd2, 8'h8D, 8'h14, 8'h00};
      4'd6:    cmd_entry = {2'd2, 8'h20, 8'h00, 8'h00};
      4'd7:    cmd_entry = {2'd1, 8'hA1, 8'h00, 8'h00};
      4'd8:    cmd_entry = {2'd1, 8'hC8, 8'h00, 8'h00};
      4'd9:    cmd_entry = {2'd2, 8'hDA, 8'h12, 8'h00};
      4'd10:   cmd_entry = {2'd2, 8'h81, 8'hCF, 8'h00};
      4'd11:   cmd_entry = {2'd2, 8'hD9, 8'hF1, 8'h00};
      4'd12:   cmd_entry = {2'd2, 8'hDB, 8'h40, 8'h00};
      4'd13:   cmd_entry = {2'd1, 8'hA4, 8'h00, 8'h00};
      4'd14:   cmd_entry = {2'd1, 8'hA6, 8'h00, 8'h00};
      default: cmd_entry = {2'd1, 8'hAF, 8'h00, 8'h00};
    endcase
  endfunction

  assign retry_nxt  = retry + RT_W'(1);
  assign slave_addr = addr_en ? 7'h3C : 7'h00;
  assign read_write = 1'b0;

  // Byte stream outputs decode from state so an asynchronous reset drops tx_valid at once
  always_comb begin
    entry    = cmd_entry(cmd_idx);
    cmd_len  = entry[25:24];
    cur_byte = (ptr == 2'd0) ? entry[23:16] : (ptr == 2'd1) ? entry[15:8] : entry[7:0];
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_last  = 1'b0;
    case (state)
      S_CTRL: tx_valid = 1'b1;
      S_CMD: begin
        tx_valid = 1'b1;
        tx_byte  = cur_byte;
        tx_last  = (ptr == cmd_len - 2'd1);
      end
`ifdef OLED_CLEAR_EN
      S_CLR: begin
        tx_valid = 1'b1;
        tx_byte  = clr_hdr ? 8'h40 : 8'h00;
        tx_last  = !clr_hdr && (clr_cnt == 11'd1023);
      end
`endif
      default: ;
    endcase
  end

  // Sequencer: power-up wait, per-command transactions, NACK retry, terminal status
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      pw_cnt  <= '0;
      retry   <= '0;
      ptr     <= 2'd0;
      addr_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cmd_idx <= 4'd0;
`ifdef OLED_CLEAR_EN
      in_clr  <= 1'b0;
      clr_hdr <= 1'b0;
      clr_cnt <= 11'd0;
`endif
    end else begin
      addr_en <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            cmd_idx <= 4'd0;
            retry   <= '0;
            pw_cnt  <= '0;
`ifdef OLED_CLEAR_EN
            in_clr  <= 1'b0;
`endif
            state   <= (PWRUP_CYCLES == 0) ? S_CTRL : S_PWRUP;
          end
        end
        S_PWRUP: begin
          if (pw_cnt == PW_LAST) state <= S_CTRL;
          else pw_cnt <= pw_cnt + PW_W'(1);
        end
        S_CTRL: begin
          if (tx_ready) begin
            ptr   <= 2'd0;
            state <= S_CMD;
          end
        end
        S_CMD: begin
          if (tx_ready) begin
            if (tx_last) state <= S_WAIT;
            else ptr <= ptr + 2'd1;
          end
        end
`ifdef OLED_CLEAR_EN
        S_CLR: begin
          if (tx_ready) begin
            if (clr_hdr) clr_hdr <= 1'b0;
            else if (tx_last) state <= S_WAIT;
            else clr_cnt <= clr_cnt + 11'd1;
          end
        end
`endif
        S_WAIT: begin
          if (tx_done) begin
            if (!tx_nack) begin
              retry <= '0;
`ifdef OLED_CLEAR_EN
              if (in_clr) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else if (cmd_idx == 4'd15) begin
                in_clr  <= 1'b1;
                clr_hdr <= 1'b1;
                clr_cnt <= 11'd0;
                state   <= S_CLR;
              end else begin
`else
              if (cmd_idx == 4'd15) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
`endif
                cmd_idx <= cmd_idx + 4'd1;
                state   <= S_CTRL;
              end
            end else if (retry_nxt < RT_MAX) begin
              retry <= retry_nxt;
`ifdef OLED_CLEAR_EN
              if (in_clr) begin
                clr_hdr <= 1'b1;
                clr_cnt <= 11'd0;
                state   <= S_CLR;
              end else begin
                state <= S_CTRL;
              end
`else
              state <= S_CTRL;
`endif
            end else begin
              retry <= retry_nxt;
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_oled_init_seq.sv
// tb/tb_i2c_oled_init_seq.sv - scoreboard bench for i2c_oled_init_seq
module tb_i2c_oled_init_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [6:0] slave_addr;
  logic       read_write;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_last;
  logic       tx_ready = 1'b1;
  logic       tx_done = 1'b0;
  logic       tx_nack = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cmd_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_trans = 0;
  bit rand_ready = 1'b0;
  int nack_cmd  = -1;
  int nack_left = 0;
  logic [8:0] exp_q[$];

`ifdef OLED_CLEAR_EN
  localparam int FULL_BYTES = 41 + 1025;
  localparam int FULL_TRANS = 17;
`else
  localparam int FULL_BYTES = 41;
  localparam int FULL_TRANS = 16;
`endif

  i2c_oled_init_seq #(.PWRUP_CYCLES(10), .RETRY_MAX(3)) dut (
    .CLK(CLK), .RST(RST), .start(start), .slave_addr(slave_addr), .read_write(read_write),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_last(tx_last), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_nack(tx_nack), .busy(busy), .done(done), .err(err), .cmd_idx(cmd_idx)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input int idx);
    logic [7:0] b[$];
    case (idx)
      0: b = '{8'hAE};         1: b = '{8'hD5, 8'h80};
      2: b = '{8'hA8, 8'h3F};  3: b = '{8'hD3, 8'h00};
      4: b = '{8'h40};         5: b = '{8'h8D, 8'h14};
      6: b = '{8'h20, 8'h00};  7: b = '{8'hA1};
      8: b = '{8'hC8};         9: b = '{8'hDA, 8'h12};
      10: b = '{8'h81, 8'hCF}; 11: b = '{8'hD9, 8'hF1};
      12: b = '{8'hDB, 8'h40}; 13: b = '{8'hA4};
      14: b = '{8'hA6};        default: b = '{8'hAF};
    endcase
    exp_q.push_back({1'b0, 8'h00});
    foreach (b[i]) exp_q.push_back({(i == b.size() - 1), b[i]});
  endtask

  task automatic push_full();
    for (int i = 0; i < 16; i++) push_cmd(i);
`ifdef OLED_CLEAR_EN
    exp_q.push_back({1'b0, 8'h40});
    for (int i = 0; i < 1024; i++) exp_q.push_back({(i == 1023), 8'h00});
`endif
  endtask

  // Pulses start and returns the number of edges until tx_valid first rises
  task automatic start_and_measure(output int n);
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 8000) begin
      @(posedge CLK); #1;
      n++;
    end
    check({name, "_timeout"}, busy, 1'b0);
  endtask

  // tx_ready driver
  initial forever begin
    @(posedge CLK); #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops expected bytes on every accept and checks hold-stability
  initial begin
    logic       prev_hold = 1'b0;
    logic [8:0] prev_val = 9'h0;
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (prev_hold) begin
          check("hold_valid", tx_valid, 1'b1);
          check("hold_data", {tx_last, tx_byte}, prev_val);
        end
        if (tx_valid && tx_ready) begin
          n_acc++;
          if (tx_last) n_trans++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {tx_last, tx_byte}, 9'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {tx_last, tx_byte}, e);
          end
        end
        prev_hold = tx_valid && !tx_ready;
        prev_val  = {tx_last, tx_byte};
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // Master model: tx_done two cycles after the accept of tx_last
  initial forever begin
    bit nk;
    @(negedge CLK);
    if (!RST && tx_valid && tx_ready && tx_last) begin
      nk = (int'(cmd_idx) == nack_cmd) && (nack_left > 0);
      if (nk) nack_left--;
      @(posedge CLK);
      @(posedge CLK); #1 tx_done = 1'b1; tx_nack = nk;
      @(posedge CLK); #1 tx_done = 1'b0; tx_nack = 1'b0;
    end
  end

  initial begin
    int n;
    int vcount;
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cmd_idx", cmd_idx, 4'd0);
    check("rst_slave_addr", slave_addr, 7'h00);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("slave_addr", slave_addr, 7'h3C);
    check("read_write", read_write, 1'b0);

    // Plain run, ready tied high
    n_acc = 0; n_trans = 0;
    push_full();
    start_and_measure(n);
    check("t1_pwrup_latency", n, 10);
    wait_idle("t1");
    check("t1_done", done, 1'b1);
    check("t1_err", err, 1'b0);
    check("t1_cmd_idx", cmd_idx, 4'd15);
    check("t1_bytes", n_acc, FULL_BYTES);
    check("t1_trans", n_trans, FULL_TRANS);
    check("t1_queue_left", exp_q.size(), 0);

    // Random backpressure
    rand_ready = 1'b1;
    n_acc = 0; n_trans = 0;
    push_full();
    start_and_measure(n);
    check("t2_pwrup_latency", n, 10);
    wait_idle("t2");
    check("t2_done", done, 1'b1);
    check("t2_bytes", n_acc, FULL_BYTES);
    check("t2_trans", n_trans, FULL_TRANS);
    check("t2_queue_left", exp_q.size(), 0);
    rand_ready = 1'b0;

    // One NACK on command 3
    nack_cmd = 3; nack_left = 1;
    n_trans = 0;
    for (int i = 0; i < 4; i++) push_cmd(i);
    push_cmd(3);
    for (int i = 4; i < 16; i++) push_cmd(i);
`ifdef OLED_CLEAR_EN
    exp_q.push_back({1'b0, 8'h40});
    for (int i = 0; i < 1024; i++) exp_q.push_back({(i == 1023), 8'h00});
`endif
    start_and_measure(n);
    wait_idle("t3");
    check("t3_done", done, 1'b1);
    check("t3_err", err, 1'b0);
    check("t3_trans", n_trans, FULL_TRANS + 1);
    check("t3_queue_left", exp_q.size(), 0);

    // Command 9 NACKed on every attempt
    nack_cmd = 9; nack_left = 100;
    for (int i = 0; i < 9; i++) push_cmd(i);
    repeat (3) push_cmd(9);
    start_and_measure(n);
    wait_idle("t4");
    check("t4_err", err, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_cmd_idx", cmd_idx, 4'd9);
    vcount = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (tx_valid) vcount++;
    end
    check("t4_no_valid_after_err", vcount, 0);
    check("t4_queue_left", exp_q.size(), 0);
    nack_cmd = -1; nack_left = 0;

    // Asynchronous reset during byte 2 of command 5
    for (int i = 0; i < 5; i++) push_cmd(i);
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h8D});
    start_and_measure(n);
    n = 0;
    while (!(tx_valid && cmd_idx == 4'd5 && tx_byte == 8'h14) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("t5_reached_cmd5_byte2", n < 500, 1'b1);
    #1 RST = 1'b1;
    #1;
    check("t5_rst_tx_valid", tx_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_cmd_idx", cmd_idx, 4'd0);
    check("t5_rst_tx_byte", tx_byte, 8'h00);
    check("t5_queue_left", exp_q.size(), 0);
    @(posedge CLK); #1 RST = 1'b0;

    // Restart after reset, with start pulses while busy
    n_acc = 0; n_trans = 0;
    push_full();
    start_and_measure(n);
    check("t6_pwrup_latency", n, 10);
    repeat (3) begin
      repeat (7) @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
    end
    wait_idle("t6");
    check("t6_done", done, 1'b1);
    check("t6_cmd_idx", cmd_idx, 4'd15);
    check("t6_bytes", n_acc, FULL_BYTES);
    check("t6_queue_left", exp_q.size(), 0);

    repeat (5) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
